// File: rtl/glbl_wb2reg_pkg.sv
// Shared types and defaults for the Wishbone to register-bus bridge.
package glbl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } wb2reg_st_t;

    localparam logic [31:0] GLBL_BASE_ADDR = 32'h3000_0000;
    localparam int          GLBL_TIMEOUT   = 16;
    localparam logic [31:0] GLBL_TO_RDATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/glbl_wb2reg_if.sv
// Wishbone-classic slave bundle between the host and the bridge.
interface glbl_wb2reg_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );

endinterface

// File: rtl/glbl_wb2reg.sv
// Wishbone-classic slave to single-outstanding register-bus bridge
// with window decode, bounded timeout and host-abort handling.
module glbl_wb2reg
    import glbl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = GLBL_BASE_ADDR,
    parameter int          TIMEOUT   = GLBL_TIMEOUT,
    parameter logic [31:0] TO_RDATA  = GLBL_TO_RDATA
) (
    input  logic          mclk,
    input  logic          reset,
    glbl_wb2reg_if.slave  wbs,
    output logic          reg_cs,
    output logic          reg_wr,
    output logic [5:0]    reg_addr,
    output logic [31:0]   reg_wdata,
    output logic [3:0]    reg_be,
    input  logic [31:0]   reg_rdata,
    input  logic          reg_ack
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    wb2reg_st_t  st_q, st_d;
    logic [7:0]  timer_q, timer_d;
    logic        abort_q, abort_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic        cs_d;
    logic        latch;
    logic        req, hit, expired;

    assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign hit     = wbs.wbs_adr_i[31:6] == BASE_ADDR[31:6];
    assign expired = timer_q == TMAX;

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = err_q;
    assign wbs.wbs_dat_o = dat_q;

    always_ff @(posedge mclk) begin
        if (reset) st_q <= IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: if (req) st_d = hit ? REQ : RESP;
            REQ:  if (reg_ack || expired) st_d = RESP;
            RESP: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // Ack beats expiry; abort only masks the host response.
    always_comb begin
        cs_d    = reg_cs;
        timer_d = timer_q;
        abort_d = abort_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        latch   = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (req && hit) begin
                    latch   = 1'b1;
                    cs_d    = 1'b1;
                    timer_d = 8'd0;
                end else if (req) begin
                    err_d = 1'b1;
                    dat_d = 32'd0;
                end
            end
            REQ: begin
                abort_d = abort_q | ~req;
                if (reg_ack) begin
                    cs_d  = 1'b0;
                    ack_d = ~abort_d;
                    dat_d = reg_rdata;
                end else if (expired) begin
                    cs_d  = 1'b0;
                    err_d = ~abort_d;
                    dat_d = TO_RDATA;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: abort_d = 1'b0;
            default: abort_d = 1'b0;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            timer_q   <= 8'd0;
            abort_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= 32'd0;
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 6'd0;
            reg_wdata <= 32'd0;
            reg_be    <= 4'd0;
        end else begin
            timer_q <= timer_d;
            abort_q <= abort_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            reg_cs  <= cs_d;
            if (latch) begin
                reg_wr    <= wbs.wbs_we_i;
                reg_addr  <= wbs.wbs_adr_i[5:0];
                reg_wdata <= wbs.wbs_dat_i;
                reg_be    <= wbs.wbs_sel_i;
            end
        end
    end

endmodule

// File: tb/tb_glbl_wb2reg.sv
// Directed bench for the Wishbone to register-bus bridge.
module tb_glbl_wb2reg;

    logic        mclk = 1'b0;
    logic        reset;
    logic        reg_cs, reg_wr;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    int checks   = 0;
    int failures = 0;

    glbl_wb2reg_if wb();

    glbl_wb2reg dut (
        .mclk      (mclk),
        .reset     (reset),
        .wbs       (wb),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic host(input logic on, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        wb.wbs_cyc_i = on;
        wb.wbs_stb_i = on;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
    endtask

    // Cycle 0 is the cycle in which stb is first sampled.
    task automatic xfer(input string tag, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] rd);
        logic [31:0] a6;
        a6 = adr & 32'h3F;
        host(1'b1, we, adr, dat, sel);
        tick;
        check({tag, ".c1.cs"}, 32'(reg_cs), 32'd1);
        check({tag, ".c1.wr"}, 32'(reg_wr), 32'(we));
        check({tag, ".c1.addr"}, 32'(reg_addr), a6);
        check({tag, ".c1.be"}, 32'(reg_be), 32'(sel));
        if (we) check({tag, ".c1.wdata"}, reg_wdata, dat);
        check({tag, ".c1.ack"}, 32'(wb.wbs_ack_o), 32'd0);
        tick;
        reg_ack   = 1'b1;
        reg_rdata = rd;
        check({tag, ".c2.cs"}, 32'(reg_cs), 32'd1);
        check({tag, ".c2.ack"}, 32'(wb.wbs_ack_o), 32'd0);
        tick;
        reg_ack = 1'b0;
        check({tag, ".c3.ack"}, 32'(wb.wbs_ack_o), 32'd1);
        check({tag, ".c3.err"}, 32'(wb.wbs_err_o), 32'd0);
        check({tag, ".c3.cs"}, 32'(reg_cs), 32'd0);
        if (!we) check({tag, ".c3.dat"}, wb.wbs_dat_o, rd);
        host(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        check({tag, ".c4.ack"}, 32'(wb.wbs_ack_o), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        reg_ack   = 1'b0;
        reg_rdata = 32'd0;
        host(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        tick;
        check("rst.cs", 32'(reg_cs), 32'd0);
        check("rst.ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rst.err", 32'(wb.wbs_err_o), 32'd0);
        check("rst.dat", wb.wbs_dat_o, 32'd0);
        check("rst.addr", 32'(reg_addr), 32'd0);
        reset = 1'b0;
        tick;

        xfer("wr", 1'b1, 32'h3000_0020, 32'hA5A5_1234, 4'hF, 32'h0);
        xfer("rd", 1'b0, 32'h3000_0024, 32'h0, 4'h3, 32'hCAFE_0001);

        // Out of window
        host(1'b1, 1'b0, 32'h3000_0100, 32'h0, 4'hF);
        tick;
        check("oow.err", 32'(wb.wbs_err_o), 32'd1);
        check("oow.ack", 32'(wb.wbs_ack_o), 32'd0);
        check("oow.dat", wb.wbs_dat_o, 32'd0);
        check("oow.cs1", 32'(reg_cs), 32'd0);
        host(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        check("oow.cs2", 32'(reg_cs), 32'd0);
        check("oow.err2", 32'(wb.wbs_err_o), 32'd0);

        // Downstream never acks
        host(1'b1, 1'b0, 32'h3000_0008, 32'h0, 4'hF);
        for (int c = 1; c <= 16; c++) begin
            tick;
            if (c == 1 || c == 16) begin
                check($sformatf("to.c%0d.cs", c), 32'(reg_cs), 32'd1);
                check($sformatf("to.c%0d.err", c), 32'(wb.wbs_err_o), 32'd0);
            end
        end
        tick;
        check("to.c17.err", 32'(wb.wbs_err_o), 32'd1);
        check("to.c17.ack", 32'(wb.wbs_ack_o), 32'd0);
        check("to.c17.cs", 32'(reg_cs), 32'd0);
        check("to.c17.dat", wb.wbs_dat_o, 32'hDEAD_BEEF);
        host(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        check("to.c18.err", 32'(wb.wbs_err_o), 32'd0);

        // Host abort in cycle 1
        host(1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick;
        host(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("ab.c1.cs", 32'(reg_cs), 32'd1);
        tick;
        reg_ack   = 1'b1;
        reg_rdata = 32'h1111_2222;
        check("ab.c2.cs", 32'(reg_cs), 32'd1);
        tick;
        reg_ack = 1'b0;
        check("ab.c3.ack", 32'(wb.wbs_ack_o), 32'd0);
        check("ab.c3.err", 32'(wb.wbs_err_o), 32'd0);
        check("ab.c3.cs", 32'(reg_cs), 32'd0);
        tick;
        check("ab.c4.ack", 32'(wb.wbs_ack_o), 32'd0);
        xfer("ab.next", 1'b0, 32'h3000_003C, 32'h0, 4'hC, 32'h0BAD_F00D);

        // Reset in cycle 1 of a write
        host(1'b1, 1'b1, 32'h3000_0004, 32'h5555_AAAA, 4'h5);
        tick;
        check("rs.c1.cs", 32'(reg_cs), 32'd1);
        reset = 1'b1;
        host(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        reset = 1'b0;
        check("rs.c2.cs", 32'(reg_cs), 32'd0);
        check("rs.c2.wr", 32'(reg_wr), 32'd0);
        check("rs.c2.addr", 32'(reg_addr), 32'd0);
        check("rs.c2.wdata", reg_wdata, 32'd0);
        check("rs.c2.be", 32'(reg_be), 32'd0);
        check("rs.c2.dat", wb.wbs_dat_o, 32'd0);
        check("rs.c2.ack", 32'(wb.wbs_ack_o), 32'd0);
        tick;
        check("rs.c3.ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rs.c3.err", 32'(wb.wbs_err_o), 32'd0);
        xfer("rs.next", 1'b1, 32'h3000_0030, 32'h0123_4567, 4'h9, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
